// File: rtl/mess_boru_hatti.sv
// rtl/mess_boru_hatti.sv - two-stage pipelined register-file ALU core with forwarding and result backpressure
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   emir           instruction word {..., op[3:0], rd, rs1, rs2}
//   emir_valid     instruction present
//   emir_ready     core accepts an instruction this cycle
//   sonuc          result data
//   sonuc_valid    result present, held until sonuc_ready
//   sonuc_ready    consumer takes the result
//   bayraklar      {N,C,Z} flag register
//   gecersiz_emir  one-cycle pulse after an undefined opcode retires
module mess_boru_hatti #(
  parameter int VERI_W     = 8,
  parameter int REG_SAYISI = 8,
  parameter int EMIR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EMIR_W-1:0] emir,
  input  logic              emir_valid,
  output logic              emir_ready,
  output logic [VERI_W-1:0] sonuc,
  output logic              sonuc_valid,
  input  logic              sonuc_ready,
  output logic [2:0]        bayraklar,
  output logic              gecersiz_emir
);

  localparam int ADR_W = $clog2(REG_SAYISI);
  localparam int SH_W  = $clog2(VERI_W);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  logic [VERI_W-1:0] regs [REG_SAYISI];

  // Incoming instruction fields
  logic [ADR_W-1:0] rs1, rs2, rd;
  logic [3:0]       op;
  logic [2*ADR_W+VERI_W-1:0] imm_ext;
  logic [VERI_W-1:0] imm;
  logic unused_bits;

  assign rs2 = emir[ADR_W-1:0];
  assign rs1 = emir[2*ADR_W-1:ADR_W];
  assign rd  = emir[3*ADR_W-1:2*ADR_W];
  assign op  = emir[3*ADR_W+3:3*ADR_W];
  // Widen first so the immediate can be either zero-extended or truncated
  assign imm_ext = {{VERI_W{1'b0}}, emir[2*ADR_W-1:0]};
  assign imm     = imm_ext[VERI_W-1:0];
  assign unused_bits = ^{emir, imm_ext};

  // Stage 2 register
  logic              s2_valid;
  logic [3:0]        s2_op;
  logic [ADR_W-1:0]  s2_rd;
  logic [VERI_W-1:0] s2_a, s2_b;

  logic [VERI_W-1:0] alu_res;
  logic              alu_c;
  logic [VERI_W:0]   sum;

  logic s2_wr, s2_out, s2_flg, s2_bad;
  logic retire, accept, fwd_ok;
  logic [VERI_W-1:0] op_a, op_b;

  assign s2_wr  = (s2_op >= OP_ADD) && (s2_op <= OP_MOV);
  assign s2_out = (s2_op >= OP_ADD) && (s2_op <= OP_CMP);
  assign s2_flg = ((s2_op >= OP_ADD) && (s2_op <= OP_SHR)) || (s2_op == OP_CMP);
  assign s2_bad = (s2_op > OP_CMP);

  assign retire     = s2_valid && (!sonuc_valid || sonuc_ready);
  assign emir_ready = !s2_valid || retire;
  assign accept     = emir_valid && emir_ready;

  // Accept implies S2 retires on the same edge, so the forwarded value is
  // exactly what the register file is about to store.
  assign fwd_ok = s2_valid && s2_wr && (s2_rd != '0);
  assign op_a   = (fwd_ok && (rs1 == s2_rd)) ? alu_res : regs[rs1];
  assign op_b   = (op == OP_LDI) ? imm :
                  (fwd_ok && (rs2 == s2_rd)) ? alu_res : regs[rs2];

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (s2_op)
      OP_ADD: begin
        sum     = {1'b0, s2_a} + {1'b0, s2_b};
        alu_res = sum[VERI_W-1:0];
        alu_c   = sum[VERI_W];
      end
      OP_SUB, OP_CMP: begin
        // Top bit of the widened difference is the unsigned borrow
        sum     = {1'b0, s2_a} - {1'b0, s2_b};
        alu_res = sum[VERI_W-1:0];
        alu_c   = sum[VERI_W];
      end
      OP_AND:  alu_res = s2_a & s2_b;
      OP_OR:   alu_res = s2_a | s2_b;
      OP_XOR:  alu_res = s2_a ^ s2_b;
      OP_SHL:  alu_res = s2_a << s2_b[SH_W-1:0];
      OP_SHR:  alu_res = s2_a >> s2_b[SH_W-1:0];
      OP_LDI:  alu_res = s2_b;
      OP_MOV:  alu_res = s2_a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_SAYISI; i++) regs[i] <= '0;
      s2_valid      <= 1'b0;
      s2_op         <= '0;
      s2_rd         <= '0;
      s2_a          <= '0;
      s2_b          <= '0;
      sonuc         <= '0;
      sonuc_valid   <= 1'b0;
      bayraklar     <= '0;
      gecersiz_emir <= 1'b0;
    end else begin
      gecersiz_emir <= retire && s2_bad;

      if (retire) begin
        // R0 is never written, so it keeps reading zero
        if (s2_wr && (s2_rd != '0)) regs[s2_rd] <= alu_res;
        if (s2_flg) bayraklar <= {alu_res[VERI_W-1], alu_c, (alu_res == '0)};
      end

      if (retire && s2_out) begin
        sonuc       <= alu_res;
        sonuc_valid <= 1'b1;
      end else if (sonuc_ready) begin
        sonuc_valid <= 1'b0;
      end

      if (accept) begin
        s2_valid <= 1'b1;
        s2_op    <= op;
        s2_rd    <= rd;
        s2_a     <= op_a;
        s2_b     <= op_b;
      end else if (retire) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mess_boru_hatti.sv
// tb/tb_mess_boru_hatti.sv - self-checking bench for mess_boru_hatti
module tb_mess_boru_hatti;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] emir = '0;
  logic        emir_valid = 1'b0;
  logic        emir_ready;
  logic [7:0]  sonuc;
  logic        sonuc_valid;
  logic        sonuc_ready = 1'b0;
  logic [2:0]  bayraklar;
  logic        gecersiz_emir;

  mess_boru_hatti #(.VERI_W(8), .REG_SAYISI(8), .EMIR_W(16)) dut (
    .clk(clk), .rst(rst), .emir(emir), .emir_valid(emir_valid), .emir_ready(emir_ready),
    .sonuc(sonuc), .sonuc_valid(sonuc_valid), .sonuc_ready(sonuc_ready),
    .bayraklar(bayraklar), .gecersiz_emir(gecersiz_emir)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Observed traffic, sampled at the falling edge
  int obs_q[$];
  int obs_cyc[$];
  int ill_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (sonuc_valid && sonuc_ready) begin
        obs_q.push_back(int'(sonuc));
        obs_cyc.push_back(cyc);
      end
      if (gecersiz_emir) ill_cnt++;
    end
  end

  // Reference model: sequential instruction-set execution
  int         m_r[8];
  logic [2:0] m_f;
  int         exp_q[$];
  int         exp_ill = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_f = 3'b000;
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
  endtask

  task automatic model_exec(input logic [15:0] w);
    int rs2 = int'(w[2:0]);
    int rs1 = int'(w[5:3]);
    int rd  = int'(w[8:6]);
    int op  = int'(w[12:9]);
    int imm = int'(w[5:0]);
    int a   = m_r[rs1];
    int b   = m_r[rs2];
    int res = 0;
    logic c = 1'b0;
    case (op)
      1:       begin res = (a + b) % 256; c = (a + b) > 255; end
      2, 10:   begin res = (a - b + 256) % 256; c = a < b; end
      3:       res = a & b;
      4:       res = a | b;
      5:       res = a ^ b;
      6:       res = (a << (b % 8)) % 256;
      7:       res = a >> (b % 8);
      8:       res = imm;
      9:       res = a;
      default: res = 0;
    endcase
    if (op >= 1 && op <= 9 && rd != 0) m_r[rd] = res;
    if (op >= 1 && op <= 10) exp_q.push_back(res);
    if ((op >= 1 && op <= 7) || op == 10) m_f = {res >= 128, c, res == 0};
    if (op >= 11) exp_ill++;
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {3'b000, op[3:0], rd[2:0], rs1[2:0], rs2[2:0]};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {3'b000, 4'd8, rd[2:0], imm[5:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [15:0] w);
    bit done = 1'b0;
    emir = w;
    emir_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (emir_ready) begin
        model_exec(w);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    emir_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout instr=%h not accepted within 200 cycles", w);
    end
  endtask

  task automatic drain();
    sonuc_ready = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sonuc_valid, sonuc, bayraklar, gecersiz_emir} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {sonuc_valid, sonuc, bayraklar, gecersiz_emir});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (emir_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", emir_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int base = obs_q.size();
    sonuc_ready = 1'b1;
    send(ldi(1, 5));
    send(ldi(2, 3));
    send(enc(1, 3, 1, 2));
    drain();
    total++;
    if (obs_q.size() != base + 3) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size() - base, 3); end
    total++;
    if (obs_q[base] !== 5 || obs_q[base+1] !== 3 || obs_q[base+2] !== 8) begin
      bad++;
      $display("FAIL basic_beats got=%0h,%0h,%0h exp=5,3,8", obs_q[base], obs_q[base+1], obs_q[base+2]);
    end
    total++;
    if (obs_cyc[base+1] != obs_cyc[base] + 1 || obs_cyc[base+2] != obs_cyc[base] + 2) begin
      bad++;
      $display("FAIL basic_back_to_back got=%0d,%0d,%0d exp consecutive", obs_cyc[base], obs_cyc[base+1], obs_cyc[base+2]);
    end
    total++;
    if (bayraklar !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b exp=000", bayraklar); end
  endtask

  task automatic test_forward();
    int base;
    send(ldi(4, 2));
    drain();
    base = obs_q.size();
    send(ldi(1, 6'h3F));
    send(enc(6, 1, 1, 4));
    send(enc(1, 2, 1, 1));
    drain();
    total++;
    if (obs_q[base] !== 'h3F || obs_q[base+1] !== 'hFC || obs_q[base+2] !== 'hF8) begin
      bad++;
      $display("FAIL fwd_beats got=%0h,%0h,%0h exp=3f,fc,f8", obs_q[base], obs_q[base+1], obs_q[base+2]);
    end
    total++;
    if (bayraklar !== 3'b110) begin bad++; $display("FAIL fwd_flags got=%b exp=110", bayraklar); end
  endtask

  task automatic test_wrap();
    int base = obs_q.size();
    send(ldi(1, 1));
    send(ldi(5, 7));
    send(enc(6, 1, 1, 5));
    send(enc(9, 2, 1, 0));
    send(enc(1, 3, 1, 2));
    drain();
    total++;
    if (obs_q[base+2] !== 'h80 || obs_q[base+4] !== 0) begin
      bad++;
      $display("FAIL wrap_add got=%0h,%0h exp=80,0", obs_q[base+2], obs_q[base+4]);
    end
    total++;
    if (bayraklar !== 3'b011) begin bad++; $display("FAIL wrap_flags got=%b exp=011", bayraklar); end
    send(enc(10, 0, 0, 1));
    send(enc(9, 6, 3, 0));
    drain();
    total++;
    if (obs_q[base+5] !== 'h80 || obs_q[base+6] !== 0) begin
      bad++;
      $display("FAIL cmp_beats got=%0h,%0h exp=80,0", obs_q[base+5], obs_q[base+6]);
    end
    total++;
    if (bayraklar !== 3'b110) begin bad++; $display("FAIL cmp_flags got=%b exp=110", bayraklar); end
  endtask

  task automatic test_backpressure();
    int base = obs_q.size();
    int unstable = 0;
    bit seen = 1'b0;
    sonuc_ready = 1'b0;
    fork
      begin
        send(ldi(1, 11));
        send(ldi(2, 22));
        send(enc(1, 3, 1, 2));
      end
      begin
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = sonuc_valid;
        end
        for (int i = 0; i < 6; i++) begin
          if (sonuc !== 8'd11 || sonuc_valid !== 1'b1 || emir_ready !== 1'b0) unstable++;
          @(negedge clk);
        end
        @(posedge clk); #1;
        sonuc_ready = 1'b1;
      end
    join
    total++;
    if (!seen || unstable != 0) begin bad++; $display("FAIL bp_hold got=%0d unstable cycles (seen=%0d) exp=0", unstable, seen); end
    drain();
    total++;
    if (obs_q.size() != base + 3 || obs_q[base] !== 11 || obs_q[base+1] !== 22 || obs_q[base+2] !== 33) begin
      bad++;
      $display("FAIL bp_drain got n=%0d %0d,%0d,%0d exp n=3 11,22,33", obs_q.size() - base, obs_q[base], obs_q[base+1], obs_q[base+2]);
    end
  endtask

  task automatic test_boundaries();
    int base = obs_q.size();
    int ib, ob;
    logic [2:0] f0;
    send(ldi(0, 6'h2A));
    send(enc(9, 5, 0, 0));
    drain();
    total++;
    if (obs_q[base] !== 'h2A || obs_q[base+1] !== 0) begin
      bad++;
      $display("FAIL r0_boundary got=%0h,%0h exp=2a,0", obs_q[base], obs_q[base+1]);
    end
    send(ldi(5, 9));
    drain();
    f0 = bayraklar;
    ib = ill_cnt;
    ob = obs_q.size();
    send(enc(13, 5, 1, 2));
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (ill_cnt != ib + 1) begin bad++; $display("FAIL illegal_pulse got=%0d cycles exp=1", ill_cnt - ib); end
    total++;
    if (obs_q.size() != ob || bayraklar !== f0 || f0 !== m_f) begin
      bad++;
      $display("FAIL illegal_side_effect got beats=%0d flags=%b exp beats=0 flags=%b", obs_q.size() - ob, bayraklar, m_f);
    end
    send(enc(9, 7, 5, 0));
    drain();
    total++;
    if (obs_q[obs_q.size()-1] !== 9) begin bad++; $display("FAIL illegal_no_write got=%0d exp=9", obs_q[obs_q.size()-1]); end
  endtask

  task automatic test_reset_stall();
    int base;
    int nz = 0;
    sonuc_ready = 1'b0;
    send(ldi(3, 4));
    send(ldi(4, 5));
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (sonuc_valid !== 1'b0 || bayraklar !== 3'b000 || gecersiz_emir !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got valid=%b flags=%b exp valid=0 flags=000", sonuc_valid, bayraklar);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (emir_ready !== 1'b1) begin bad++; $display("FAIL reset_stall_ready got=%b exp=1", emir_ready); end
    @(posedge clk); #1;
    sonuc_ready = 1'b1;
    base = obs_q.size();
    for (int k = 0; k < 8; k++) send(enc(9, 0, k, 0));
    drain();
    for (int k = 0; k < 8; k++) if (obs_q[base+k] !== 0) nz++;
    total++;
    if (obs_q.size() != base + 8 || nz != 0) begin
      bad++;
      $display("FAIL reset_regs got beats=%0d nonzero=%0d exp beats=8 nonzero=0", obs_q.size() - base, nz);
    end
  endtask

  task automatic test_random();
    int base = obs_q.size();
    int eb = exp_q.size();
    int ib = ill_cnt;
    int ie = exp_ill;
    bit done = 1'b0;
    logic [15:0] w;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          w = 16'($urandom);
          if ($urandom % 4 == 0) w[12:9] = 4'd8;
          send(w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          sonuc_ready = ($urandom % 4) != 0;
        end
      end
    join
    drain();
    total++;
    if (obs_q.size() - base != exp_q.size() - eb) begin
      bad++;
      $display("FAIL rand_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size() - eb);
    end
    for (int i = base; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_beat idx=%0d got=%0h exp=%0h", i - base, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (bayraklar !== m_f) begin bad++; $display("FAIL rand_flags got=%b exp=%b", bayraklar, m_f); end
    total++;
    if (ill_cnt - ib != exp_ill - ie) begin
      bad++;
      $display("FAIL rand_illegal got=%0d exp=%0d", ill_cnt - ib, exp_ill - ie);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_wrap();
    test_backpressure();
    test_boundaries();
    test_reset_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mess_boru_hatti.md
Name: mess_boru_hatti

Overview:
- Parametrised, two-stage pipelined successor of the register-file + ALU processing element.
- Accepts one instruction per cycle on a valid/ready handshake, reads a REG_SAYISI x VERI_W register file, executes, writes back, and streams each result out on a valid/ready result port.
- Adds operand forwarding, Z/C/N flags, output backpressure and illegal-opcode detection.
- Sits between the instruction sequencer and the result consumer.

Parameters:
- VERI_W, 8: data/register width in bits (>=4).
- REG_SAYISI, 8: number of registers, power of two >=4. ADR_W = clog2(REG_SAYISI) is derived.
- EMIR_W, 16: instruction width, must be >= 4+3*ADR_W. Bits above 4+3*ADR_W are ignored.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- emir  in  EMIR_W  instruction word.
- emir_valid  in  1  instruction present.
- emir_ready  out  1  core can accept an instruction this cycle.
- sonuc  out  VERI_W  result data.
- sonuc_valid  out  1  result present.
- sonuc_ready  in  1  consumer takes the result.
- bayraklar  out  3  {N,C,Z} flag register.
- gecersiz_emir  out  1  one-cycle pulse when an undefined opcode executes.

Behaviour:
- Instruction fields:
  - rs2 = emir[ADR_W-1:0]
  - rs1 = emir[2ADR_W-1:ADR_W]
  - rd = emir[3ADR_W-1:2ADR_W]
  - op = emir[3ADR_W+3:3ADR_W]
  - imm = emir[2ADR_W-1:0], zero-extended or truncated to VERI_W.
- Opcodes, with a=R[rs1], b=R[rs2]:
  - 0 NOP
  - 1 ADD a+b
  - 2 SUB a-b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL a<<b[clog2(VERI_W)-1:0]
  - 7 SHR, logical, same shift amount as SHL
  - 8 LDI imm
  - 9 MOV a
  - 10 CMP a-b
  - 11-15 undefined.
- Results are VERI_W bits and wrap modulo 2^VERI_W.
- Register R0 always reads 0. Writes to R0 are discarded, but the result still appears on sonuc.
- Stage 1 (S1): an instruction is accepted on an edge where emir_valid && emir_ready. Operands are read and latched together with op and rd into the S2 register.
- Stage 2 (S2): the ALU is combinational on the latched operands. S2 retires on the edge where it is occupied and the output register is free (sonuc_valid==0 || sonuc_ready==1). On that edge:
  - the register file writes R[rd] for ops 1-9;
  - sonuc and sonuc_valid load for ops 1-10;
  - flags update;
  - NOP and undefined opcodes retire without producing a result beat.
- Latency: accepted at edge N, retired at edge N+1, so sonuc_valid is high from N+1 when unstalled. Throughput is 1 instruction per cycle.
- Forwarding: if S2 holds an instruction writing rd!=0 and the incoming rs1 or rs2 equals that rd, the S2 ALU result is used instead of the register file. Back-to-back dependent instructions therefore need no bubble.
- Stall:
  - emir_ready = !(S2 occupied && S2 cannot retire).
  - While stalled, S2, its forwarded value, the register file and the flags hold.
  - sonuc and sonuc_valid stay stable until sonuc_ready.
- sonuc_valid clears on an edge with sonuc_ready=1 when no new result loads. A simultaneous consume and load keeps it at 1 with the new data.
- Flags:
  - Z = (result==0) for ops 1-7 and 10.
  - N = result MSB for ops 1-7 and 10.
  - C = carry-out for ADD; borrow (a<b unsigned) for SUB/CMP; cleared for ops 3-7.
  - LDI, MOV and NOP leave all flags unchanged.
- gecersiz_emir is high for exactly the cycle after an undefined opcode retires. It does not write the register file or flags and produces no result beat.
- Reset (rst=0, any time, including mid-stall):
  - all registers R0..R(REG_SAYISI-1) = 0;
  - S2 emptied;
  - sonuc = 0, sonuc_valid = 0, bayraklar = 0, gecersiz_emir = 0;
  - emir_ready = 1 immediately after release;
  - an in-flight instruction is discarded.

Test Plan:
- Reset, then LDI R1,5; LDI R2,3; ADD R3,R1,R2 issued back-to-back with sonuc_ready=1 -> sonuc beats 5, 3, 8 on consecutive cycles; bayraklar = 000 after the ADD.
- Forwarding chain: LDI R1,0x3F then SHL R1,R1,R? with R4=2, then ADD R2,R1,R1 back-to-back -> sonuc beats 0x3F, 0xFC, 0xF8; after the ADD, C=1 and N=1.
- Wrap and flags: R1=0x80, R2=0x80, ADD R3,R1,R2 -> sonuc 0x00, Z=1, C=1, N=0. Then CMP R0,R1 -> sonuc 0x80, C=1 (borrow), R3 still reads 0x00.
- Backpressure: hold sonuc_ready=0 and issue 3 instructions -> first result held stable, emir_ready drops after the second accept. Raise sonuc_ready -> results drain in order with none lost or duplicated.
- Boundaries: LDI R0,0x2A -> sonuc 0x2A, but a later MOV R5,R0 gives 0. Opcode 13 -> gecersiz_emir pulses 1 cycle, no sonuc beat, flags unchanged.
- Assert rst=0 while stalled with a pending result -> sonuc_valid=0 and bayraklar=0 immediately. After release, all registers read 0 and emir_ready=1.
